mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port RAM.
// Round-robin on contention, fixed-latency reads, one-cycle completion acks.
module mem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_ack_o,
    output logic [31:0] dm_rdata_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic        busy_o,
    output logic        owner_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        grant_s;
    logic        win_dm_s;
    logic        cap_last_s;

    logic        arm_r;
    logic        owner_r;
    logic        we_r;
    logic        ram_we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [1:0]  cnt_r;
    logic [31:0] if_rdata_r;
    logic [31:0] dm_rdata_r;
    logic        if_ack_r;
    logic        dm_ack_r;
    logic        busy_r;

    assign cap_last_s = (state_r == WAIT) && (cnt_r == 2'd0);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and grant decision; arm_r keeps the first edge after reset grant-free.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        win_dm_s     = owner_r;
        case (state_r)
            IDLE: begin
                if (arm_r && (if_req_i || dm_req_i)) begin
                    grant_s      = 1'b1;
                    state_next_s = ACCESS;
                    if (if_req_i && dm_req_i) begin
                        win_dm_s = ~owner_r;
                    end else begin
                        win_dm_s = dm_req_i;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (we_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == 2'd0) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Request latching, wait counter, read capture and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_r      <= 1'b0;
            owner_r    <= 1'b1;
            we_r       <= 1'b0;
            ram_we_r   <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            cnt_r      <= 2'd0;
            if_rdata_r <= 32'h0000_0000;
            dm_rdata_r <= 32'h0000_0000;
            if_ack_r   <= 1'b0;
            dm_ack_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            arm_r  <= 1'b1;
            busy_r <= (state_next_s != IDLE);
            if (grant_s) begin
                owner_r  <= win_dm_s;
                addr_r   <= win_dm_s ? dm_addr_i : if_addr_i;
                wdata_r  <= win_dm_s ? dm_wdata_i : 32'h0000_0000;
                we_r     <= win_dm_s & dm_we_i;
                ram_we_r <= win_dm_s & dm_we_i;
            end else begin
                ram_we_r <= 1'b0;
            end
            if (state_r == ACCESS) begin
                cnt_r <= 2'(RD_LAT - 1);
            end else if ((state_r == WAIT) && (cnt_r != 2'd0)) begin
                cnt_r <= cnt_r - 2'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (cap_last_s) begin
                if (owner_r) begin
                    dm_rdata_r <= ram_rdata_i;
                end else begin
                    if_rdata_r <= ram_rdata_i;
                end
            end
            // DONE always follows a single entry, so acks are exactly one cycle wide.
            if_ack_r <= (state_next_s == DONE) & ~owner_r;
            dm_ack_r <= (state_next_s == DONE) & owner_r;
        end
    end

    assign if_ack_o    = if_ack_r;
    assign dm_ack_o    = dm_ack_r;
    assign if_rdata_o  = if_rdata_r;
    assign dm_rdata_o  = dm_rdata_r;
    assign ram_we_o    = ram_we_r;
    assign ram_addr_o  = addr_r;
    assign ram_wdata_o = wdata_r;
    assign busy_o      = busy_r;
    assign owner_o     = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT 1 and 3) share stimulus and are
// checked each cycle against a transaction-level model plus directed literals.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;

    logic        if_ack [2];
    logic [31:0] if_rdata [2];
    logic        dm_ack [2];
    logic [31:0] dm_rdata [2];
    logic        ram_we [2];
    logic [31:0] ram_addr [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];
    logic        busy [2];
    logic        owner [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    always_comb begin
        ram_rdata[0] = ram_word(ram_addr[0]);
        ram_rdata[1] = ram_word(ram_addr[1]);
    end

    mem_arbiter #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack[0]), .if_rdata_o(if_rdata[0]),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ack_o(dm_ack[0]), .dm_rdata_o(dm_rdata[0]),
        .ram_we_o(ram_we[0]), .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]),
        .ram_rdata_i(ram_rdata[0]), .busy_o(busy[0]), .owner_o(owner[0])
    );

    mem_arbiter #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack[1]), .if_rdata_o(if_rdata[1]),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ack_o(dm_ack[1]), .dm_rdata_o(dm_rdata[1]),
        .ram_we_o(ram_we[1]), .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]),
        .ram_rdata_i(ram_rdata[1]), .busy_o(busy[1]), .owner_o(owner[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Transaction model: k counts cycles since grant (0 = idle), dur = total busy cycles.
    int          m_k [2];
    int          m_dur [2];
    logic        m_arm [2];
    logic        m_owner [2];
    logic        m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_ifrd [2];
    logic [31:0] m_dmrd [2];

    task automatic model_reset(input int i);
        m_k[i] = 0; m_dur[i] = 0; m_arm[i] = 1'b0; m_owner[i] = 1'b1; m_we[i] = 1'b0;
        m_addr[i] = 32'h0; m_wdata[i] = 32'h0; m_ifrd[i] = 32'h0; m_dmrd[i] = 32'h0;
    endtask

    task automatic model_step(input int i);
        int   lat;
        logic to_dm;
        lat = (i == 0) ? 1 : 3;
        if (!reset) begin
            model_reset(i);
        end else if (!m_arm[i]) begin
            m_arm[i] = 1'b1;
        end else if (m_k[i] == 0) begin
            if (if_req || dm_req) begin
                to_dm = (if_req && dm_req) ? !m_owner[i] : dm_req;
                m_owner[i] = to_dm;
                m_addr[i]  = to_dm ? dm_addr : if_addr;
                m_wdata[i] = dm_wdata;
                m_we[i]    = to_dm && dm_we;
                m_dur[i]   = m_we[i] ? 2 : 2 + lat;
                m_k[i]     = 1;
            end
        end else begin
            if (!m_we[i] && m_k[i] == m_dur[i] - 1) begin
                if (m_owner[i]) m_dmrd[i] = ram_word(m_addr[i]);
                else            m_ifrd[i] = ram_word(m_addr[i]);
            end
            m_k[i] = (m_k[i] == m_dur[i]) ? 0 : m_k[i] + 1;
        end
    endtask

    task automatic model_compare(input int i);
        string p;
        logic  done;
        p    = (i == 0) ? "L1" : "L3";
        done = (m_k[i] != 0) && (m_k[i] == m_dur[i]);
        chk1({p, " busy"}, busy[i], m_k[i] != 0);
        chk1({p, " owner"}, owner[i], m_owner[i]);
        chk1({p, " ram_we"}, ram_we[i], m_we[i] && m_k[i] == 1);
        chk1({p, " if_ack"}, if_ack[i], done && !m_owner[i]);
        chk1({p, " dm_ack"}, dm_ack[i], done && m_owner[i]);
        chk1({p, " ack_excl"}, if_ack[i] && dm_ack[i], 1'b0);
        chk({p, " if_rdata"}, if_rdata[i], m_ifrd[i]);
        chk({p, " dm_rdata"}, dm_rdata[i], m_dmrd[i]);
        if (m_k[i] >= 1 && m_k[i] < m_dur[i]) chk({p, " ram_addr"}, ram_addr[i], m_addr[i]);
        if (m_we[i] && m_k[i] == 1) chk({p, " ram_wdata"}, ram_wdata[i], m_wdata[i]);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                model_step(i);
                model_compare(i);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk1({tag, " busy"}, busy[i], 1'b0);
            chk1({tag, " owner"}, owner[i], 1'b1);
            chk1({tag, " if_ack"}, if_ack[i], 1'b0);
            chk1({tag, " dm_ack"}, dm_ack[i], 1'b0);
            chk1({tag, " ram_we"}, ram_we[i], 1'b0);
            chk({tag, " ram_addr"}, ram_addr[i], 32'h0);
            chk({tag, " ram_wdata"}, ram_wdata[i], 32'h0);
            chk({tag, " if_rdata"}, if_rdata[i], 32'h0);
            chk({tag, " dm_rdata"}, dm_rdata[i], 32'h0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy[0] || busy[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy[0] || busy[1]) chk1("idle_timeout", 1'b1, 1'b0);
    endtask

    int   seq[$];
    logic own_q[$];

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Fetch read of 0x10, RD_LAT=1: ack only in T+3.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        @(negedge clk);
        chk("s1 addr", ram_addr[0], 32'h0000_0010);
        chk1("s1 busy", busy[0], 1'b1);
        chk1("s1 owner", owner[0], 1'b0);
        chk1("s1 we", ram_we[0], 1'b0);
        @(negedge clk);
        chk1("s1 ack_t2", if_ack[0], 1'b0);
        @(negedge clk);
        chk1("s1 ack_t3", if_ack[0], 1'b1);
        chk("s1 rdata", if_rdata[0], 32'hDEAD_BEEF);
        if_req = 1'b0;
        @(negedge clk);
        chk1("s1 ack_t4", if_ack[0], 1'b0);
        wait_idle();

        // Data write 0x40 <= 0x12345678.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0040; dm_wdata = 32'h1234_5678;
        @(negedge clk);
        chk1("s2 we_t1", ram_we[0], 1'b1);
        chk("s2 addr", ram_addr[0], 32'h0000_0040);
        chk("s2 wdata", ram_wdata[0], 32'h1234_5678);
        chk1("s2 ack_t1", dm_ack[0], 1'b0);
        @(negedge clk);
        chk1("s2 we_t2", ram_we[0], 1'b0);
        chk1("s2 ack_t2", dm_ack[0], 1'b1);
        chk("s2 dm_rdata", dm_rdata[0], 32'h0);
        dm_req = 1'b0;
        wait_idle();

        // Write whose request drops right after the grant.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0044; dm_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk1("s3 we", ram_we[0], 1'b1);
        chk("s3 wdata", ram_wdata[0], 32'hCAFE_F00D);
        dm_req = 1'b0;
        @(negedge clk);
        chk1("s3 ack", dm_ack[0], 1'b1);
        wait_idle();

        // RD_LAT=3 data read of 0x80.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0080;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("s4 addr_stable", ram_addr[1], 32'h0000_0080);
            chk1("s4 no_ack", dm_ack[1], 1'b0);
        end
        @(negedge clk);
        chk1("s4 ack_t5", dm_ack[1], 1'b1);
        chk("s4 rdata", dm_rdata[1], 32'h0080_FF7F);
        dm_req = 1'b0;
        wait_idle();

        // Contention from reset: fetch, data, fetch.
        reset = 1'b0;
        #1;
        check_reset_vals("rst2");
        @(negedge clk);
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0200; dm_wdata = 32'h0000_55AA;
        for (int c = 0; c < 40 && seq.size() < 3; c++) begin
            @(negedge clk);
            if (if_ack[0] && dm_ack[0]) begin
                seq.push_back(2); own_q.push_back(owner[0]);
            end else if (if_ack[0]) begin
                seq.push_back(0); own_q.push_back(owner[0]);
            end else if (dm_ack[0]) begin
                seq.push_back(1); own_q.push_back(owner[0]);
            end
        end
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        chk("s5 ack_count", seq.size(), 32'd3);
        if (seq.size() >= 3) begin
            chk("s5 grant0", seq[0], 32'd0);
            chk("s5 grant1", seq[1], 32'd1);
            chk("s5 grant2", seq[2], 32'd0);
            chk1("s5 owner0", own_q[0], 1'b0);
            chk1("s5 owner1", own_q[1], 1'b1);
            chk1("s5 owner2", own_q[2], 1'b0);
        end
        wait_idle();

        // Reset during WAIT, then the held fetch is served normally.
        if_req = 1'b1; if_addr = 32'h0000_0020;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("rst_wait");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk1("s6 no_early_grant", busy[0], 1'b0);
        @(negedge clk);
        chk1("s6 grant", busy[0], 1'b1);
        chk1("s6 owner", owner[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk1("s6 ack", if_ack[0], 1'b1);
        chk("s6 rdata", if_rdata[0], 32'h0020_FFDF);
        if_req = 1'b0;
        wait_idle();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
